// File: rtl/memory_stage.sv
// Memory-access stage of the 64-bit RISC-V pipeline: EX/MEM register, data-bus
// request generation, load extraction/extension, store alignment and MEM/WB register.
module memory_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [63:0] in_pc,
   input  logic [63:0] in_alu_out,
   input  logic [63:0] in_srcb,
   input  logic [4:0]  in_dst,
   input  logic        in_regwrite,
   input  logic        in_memread,
   input  logic        in_memwrite,
   input  logic [1:0]  in_msize,
   input  logic        in_unsigned,
   output logic        dreq_valid,
   output logic [63:0] dreq_addr,
   output logic [2:0]  dreq_size,
   output logic [7:0]  dreq_strobe,
   output logic [63:0] dreq_data,
   input  logic        dresp_data_ok,
   input  logic [63:0] dresp_data,
   output logic        stallM,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [63:0] out_result,
   output logic [4:0]  out_dst,
   output logic        out_regwrite,
   output logic        out_misalign,
   output logic [31:0] stall_cycles
);

   typedef enum logic {IDLE, REQ} stateType;

   stateType state, nextState;

   // EX/MEM register
   logic        rValid;
   logic [63:0] rPc;
   logic [63:0] rAluOut;
   logic [63:0] rSrcb;
   logic [4:0]  rDst;
   logic        rRegwrite;
   logic        rMemread;
   logic        rMemwrite;
   logic [1:0]  rMsize;
   logic        rUnsigned;

   logic [2:0]  offset;
   logic        rMem;
   logic        misalign;
   logic        inMisalign;
   logic        inStartsReq;
   logic [7:0]  baseStrobe;
   logic [63:0] rawData;
   logic [63:0] loadData;

   // Address bits that must be zero for an access of 2^msize bytes.
   function automatic logic [2:0] alignMask(input logic [1:0] msize);
      logic [2:0] mask;
      case (msize)
         2'd0:    mask = 3'b000;
         2'd1:    mask = 3'b001;
         2'd2:    mask = 3'b011;
         default: mask = 3'b111;
      endcase
      return mask;
   endfunction

   assign offset      = rAluOut[2:0];
   assign rMem        = rMemread | rMemwrite;
   assign misalign    = rMem & (|(offset & alignMask(rMsize)));
   assign inMisalign  = |(in_alu_out[2:0] & alignMask(in_msize));
   assign inStartsReq = in_valid & (in_memread | in_memwrite) & ~inMisalign;

   // NOTE: this design resets synchronously; every register, including the wide
   // datapath fields, is cleared so the dreq_* outputs read zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rValid    <= 1'b0;
         rPc       <= '0;
         rAluOut   <= '0;
         rSrcb     <= '0;
         rDst      <= '0;
         rRegwrite <= 1'b0;
         rMemread  <= 1'b0;
         rMemwrite <= 1'b0;
         rMsize    <= '0;
         rUnsigned <= 1'b0;
      end else if (!stallM) begin
         rValid    <= in_valid;
         rPc       <= in_pc;
         rAluOut   <= in_alu_out;
         rSrcb     <= in_srcb;
         rDst      <= in_dst;
         rRegwrite <= in_regwrite;
         rMemread  <= in_memread;
         rMemwrite <= in_memwrite;
         rMsize    <= in_msize;
         rUnsigned <= in_unsigned;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // NOTE: every output of this block is defaulted first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      nextState  = state;
      dreq_valid = 1'b0;
      stallM     = 1'b0;
      case (state)
         IDLE: begin
            if (inStartsReq) nextState = REQ;
         end
         REQ: begin
            dreq_valid = 1'b1;
            stallM     = ~dresp_data_ok;
            if (dresp_data_ok) nextState = inStartsReq ? REQ : IDLE;
         end
      endcase
   end

   // Request side is driven straight from R, so it is stable while stalled.
   always_comb begin
      case (rMsize)
         2'd0:    baseStrobe = 8'h01;
         2'd1:    baseStrobe = 8'h03;
         2'd2:    baseStrobe = 8'h0F;
         default: baseStrobe = 8'hFF;
      endcase
   end

   assign dreq_addr   = rAluOut;
   assign dreq_size   = {1'b0, rMsize};
   assign dreq_strobe = rMemwrite ? (baseStrobe << offset) : 8'h00;
   assign dreq_data   = rSrcb << {offset, 3'b000};

   assign rawData = dresp_data >> {offset, 3'b000};

   always_comb begin
      case (rMsize)
         2'd0:    loadData = {{56{~rUnsigned & rawData[7]}},  rawData[7:0]};
         2'd1:    loadData = {{48{~rUnsigned & rawData[15]}}, rawData[15:0]};
         2'd2:    loadData = {{32{~rUnsigned & rawData[31]}}, rawData[31:0]};
         default: loadData = rawData;
      endcase
   end

   // MEM/WB register; a stall inserts a bubble toward writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_result   <= '0;
         out_dst      <= '0;
         out_regwrite <= 1'b0;
         out_misalign <= 1'b0;
      end else if (!stallM) begin
         out_valid    <= rValid;
         out_pc       <= rPc;
         out_result   <= rMemread ? loadData : rAluOut;
         out_dst      <= rDst;
         out_regwrite <= rRegwrite & ~misalign & ~rMemwrite;
         out_misalign <= rValid & rMem & misalign;
      end else begin
         out_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)       stall_cycles <= '0;
      else if (stallM) stall_cycles <= stall_cycles + 32'd1;
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [63:0] in_pc;
   logic [63:0] in_alu_out;
   logic [63:0] in_srcb;
   logic [4:0]  in_dst;
   logic        in_regwrite;
   logic        in_memread;
   logic        in_memwrite;
   logic [1:0]  in_msize;
   logic        in_unsigned;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic [2:0]  dreq_size;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_data;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        stallM;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [63:0] out_result;
   logic [4:0]  out_dst;
   logic        out_regwrite;
   logic        out_misalign;
   logic [31:0] stall_cycles;

   always #5 clk = ~clk;

   memory_stage dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out), .in_srcb(in_srcb),
      .in_dst(in_dst), .in_regwrite(in_regwrite), .in_memread(in_memread),
      .in_memwrite(in_memwrite), .in_msize(in_msize), .in_unsigned(in_unsigned),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
      .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
      .stallM(stallM), .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
      .out_dst(out_dst), .out_regwrite(out_regwrite), .out_misalign(out_misalign),
      .stall_cycles(stall_cycles)
   );

   typedef struct {
      logic        valid;
      logic [63:0] pc;
      logic [63:0] alu;
      logic [63:0] srcb;
      logic [4:0]  dst;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [1:0]  msize;
      logic        uns;
   } opT;

   typedef struct {
      opT          op;
      int          delay;
      logic [63:0] rdata;
      logic [63:0] expResult;
      logic        expRw;
      logic        expMis;
      logic [7:0]  expStrobe;
      logic [63:0] expData;
   } vecT;

   typedef struct {
      logic        valid;
      logic [63:0] pc;
      logic [4:0]  dst;
      logic        rw;
      logic        mis;
      logic [63:0] result;
      logic        skipResult;
   } outT;

   int checks = 0;
   int failures = 0;
   int expStall = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic opT mkOp(input logic [63:0] pc, input logic [63:0] alu,
                               input logic [63:0] srcb, input logic [4:0] dst,
                               input logic rw, input logic mr, input logic mw,
                               input logic [1:0] msize, input logic uns);
      opT o;
      o.valid = 1'b1; o.pc = pc; o.alu = alu; o.srcb = srcb; o.dst = dst;
      o.rw = rw; o.mr = mr; o.mw = mw; o.msize = msize; o.uns = uns;
      return o;
   endfunction

   task automatic driveOp(input opT o);
      in_valid = o.valid; in_pc = o.pc; in_alu_out = o.alu; in_srcb = o.srcb;
      in_dst = o.dst; in_regwrite = o.rw; in_memread = o.mr; in_memwrite = o.mw;
      in_msize = o.msize; in_unsigned = o.uns;
   endtask

   task automatic driveBubble();
      opT o;
      o = mkOp(64'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      o.valid = 1'b0;
      driveOp(o);
   endtask

   // Reference model: behaviour computed from byte counts and offsets.
   function automatic logic isMisaligned(input opT o);
      int bytes;
      bytes = 1 << o.msize;
      return (o.mr || o.mw) && ((int'(o.alu[2:0]) % bytes) != 0);
   endfunction

   function automatic logic [63:0] modelLoad(input opT o, input logic [63:0] rdata);
      int bytes;
      int off;
      logic [63:0] raw;
      logic [63:0] m;
      logic [63:0] v;
      bytes = 1 << o.msize;
      off = int'(o.alu[2:0]);
      raw = rdata >> (8 * off);
      m = (bytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * bytes)) - 64'd1);
      v = raw & m;
      if (!o.uns && bytes < 8 && v[8 * bytes - 1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [7:0] modelStrobe(input opT o);
      logic [7:0] s;
      int bytes;
      int off;
      bytes = 1 << o.msize;
      off = int'(o.alu[2:0]);
      s = 8'h00;
      for (int i = 0; i < 8; i++)
         if (o.mw && i >= off && i < off + bytes) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] modelData(input opT o);
      return o.srcb << (8 * int'(o.alu[2:0]));
   endfunction

   function automatic outT modelOut(input opT o, input logic [63:0] rdata);
      outT r;
      logic mis;
      mis = isMisaligned(o);
      r.valid = o.valid;
      r.pc = o.pc;
      r.dst = o.dst;
      r.rw = o.rw && !mis && !o.mw;
      r.mis = o.valid && mis;
      r.result = o.mr ? modelLoad(o, rdata) : o.alu;
      r.skipResult = o.mr && mis;
      return r;
   endfunction

   function automatic opT randOp();
      opT o;
      int kind;
      o.valid = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 2);
      o.mr = (kind == 1);
      o.mw = (kind == 2);
      o.msize = 2'($urandom_range(0, 3));
      o.alu = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) o.alu = o.alu & ~((64'd1 << o.msize) - 64'd1);
      o.pc = {$urandom, $urandom};
      o.srcb = {$urandom, $urandom};
      o.dst = 5'($urandom);
      o.rw = 1'($urandom);
      o.uns = 1'($urandom);
      return o;
   endfunction

   task automatic applyVec(input vecT v, input string tag);
      logic isReq;
      isReq = (v.op.mr || v.op.mw) && !v.expMis;
      driveOp(v.op);
      dresp_data_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      driveBubble();
      if (isReq) begin
         for (int c = 0; c <= v.delay; c++) begin
            dresp_data_ok = (c == v.delay);
            dresp_data = (c == v.delay) ? v.rdata : {$urandom, $urandom};
            #1;
            check({tag, ".dreq_valid"}, 64'(dreq_valid), 64'd1);
            check({tag, ".dreq_addr"}, dreq_addr, v.op.alu);
            check({tag, ".dreq_size"}, 64'(dreq_size), 64'(v.op.msize));
            check({tag, ".dreq_strobe"}, 64'(dreq_strobe), 64'(v.expStrobe));
            if (v.op.mw) check({tag, ".dreq_data"}, dreq_data, v.expData);
            check({tag, ".stallM"}, 64'(stallM), 64'(c < v.delay));
            @(posedge clk);
            @(negedge clk);
         end
         dresp_data_ok = 1'b0;
         expStall += v.delay;
      end else begin
         #1;
         check({tag, ".dreq_valid"}, 64'(dreq_valid), 64'd0);
         check({tag, ".stallM"}, 64'(stallM), 64'd0);
         @(posedge clk);
         @(negedge clk);
      end
      #1;
      check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".out_pc"}, out_pc, v.op.pc);
      check({tag, ".out_dst"}, 64'(out_dst), 64'(v.op.dst));
      check({tag, ".out_regwrite"}, 64'(out_regwrite), 64'(v.expRw));
      check({tag, ".out_misalign"}, 64'(out_misalign), 64'(v.expMis));
      if (!(v.expMis && v.op.mr)) check({tag, ".out_result"}, out_result, v.expResult);
      check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(expStall));
   endtask

   vecT vecs[10];
   opT  stageOp;
   opT  nextOp;
   outT expOut;
   int  stageWait;
   int  stallCnt;

   initial begin
      logic busy;
      logic ok;
      logic stall;
      logic [63:0] rdata;

      // ALU result passes through unchanged.
      vecs[0] = '{mkOp(64'h100, 64'h1234, 64'h0, 5'd3, 1, 0, 0, 2'd3, 0), 0, 64'h0,
                  64'h1234, 1'b1, 1'b0, 8'h00, 64'h0};
      // lb 0x1003, three wait cycles.
      vecs[1] = '{mkOp(64'h104, 64'h1003, 64'h0, 5'd4, 1, 1, 0, 2'd0, 0), 3, 64'h0000_0000_8000_0000,
                  64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 8'h00, 64'h0};
      // lhu 0x1006, immediate response.
      vecs[2] = '{mkOp(64'h108, 64'h1006, 64'h0, 5'd5, 1, 1, 0, 2'd1, 1), 0, 64'hBEEF_0000_0000_0000,
                  64'h0000_0000_0000_BEEF, 1'b1, 1'b0, 8'h00, 64'h0};
      // sw 0x1004.
      vecs[3] = '{mkOp(64'h10C, 64'h1004, 64'hDEAD_BEEF, 5'd6, 1, 0, 1, 2'd2, 0), 1, 64'h0,
                  64'h1004, 1'b0, 1'b0, 8'hF0, 64'hDEAD_BEEF_0000_0000};
      // ld 0x1002 misaligned.
      vecs[4] = '{mkOp(64'h110, 64'h1002, 64'h0, 5'd7, 1, 1, 0, 2'd3, 0), 0, 64'h0,
                  64'h0, 1'b0, 1'b1, 8'h00, 64'h0};
      // lw 0x1000 negative.
      vecs[5] = '{mkOp(64'h114, 64'h1000, 64'h0, 5'd8, 1, 1, 0, 2'd2, 0), 2, 64'h1234_5678_8000_0001,
                  64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0, 8'h00, 64'h0};
      // sb 0x1007: top lane only.
      vecs[6] = '{mkOp(64'h118, 64'h1007, 64'h1122_3344_5566_77AB, 5'd9, 0, 0, 1, 2'd0, 0), 0, 64'h0,
                  64'h1007, 1'b0, 1'b0, 8'h80, 64'hAB00_0000_0000_0000};
      // sh 0x1003 misaligned store.
      vecs[7] = '{mkOp(64'h11C, 64'h1003, 64'h55AA, 5'd10, 1, 0, 1, 2'd1, 0), 0, 64'h0,
                  64'h1003, 1'b0, 1'b1, 8'h00, 64'h0};
      // ALU without register write.
      vecs[8] = '{mkOp(64'h120, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd11, 0, 0, 0, 2'd0, 0), 0, 64'h0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 8'h00, 64'h0};
      // lwu 0x1004, zero-extended.
      vecs[9] = '{mkOp(64'h124, 64'h1004, 64'h0, 5'd12, 1, 1, 0, 2'd2, 1), 1, 64'hF000_0001_0000_0000,
                  64'h0000_0000_F000_0001, 1'b1, 1'b0, 8'h00, 64'h0};

      reset = 1'b1;
      driveBubble();
      dresp_data_ok = 1'b0;
      dresp_data = 64'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.out_pc", out_pc, 64'd0);
      check("reset.out_result", out_result, 64'd0);
      check("reset.out_dst", 64'(out_dst), 64'd0);
      check("reset.out_regwrite", 64'(out_regwrite), 64'd0);
      check("reset.out_misalign", 64'(out_misalign), 64'd0);
      check("reset.dreq_valid", 64'(dreq_valid), 64'd0);
      check("reset.stallM", 64'(stallM), 64'd0);
      check("reset.stall_cycles", 64'(stall_cycles), 64'd0);
      @(negedge clk);

      for (int i = 0; i < 10; i++) applyVec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back sd then ld with no idle cycle between requests.
      driveOp(mkOp(64'h200, 64'h1010, 64'hCAFE_F00D_1234_5678, 5'd1, 1, 0, 1, 2'd3, 0));
      @(posedge clk);
      @(negedge clk);
      driveOp(mkOp(64'h204, 64'h1018, 64'h0, 5'd2, 1, 1, 0, 2'd3, 0));
      dresp_data_ok = 1'b1;
      dresp_data = 64'h0;
      #1;
      check("b2b.sd_strobe", 64'(dreq_strobe), 64'hFF);
      check("b2b.sd_data", dreq_data, 64'hCAFE_F00D_1234_5678);
      check("b2b.sd_stallM", 64'(stallM), 64'd0);
      @(posedge clk);
      @(negedge clk);
      driveBubble();
      dresp_data = 64'h0123_4567_89AB_CDEF;
      #1;
      check("b2b.ld_dreq_valid", 64'(dreq_valid), 64'd1);
      check("b2b.ld_addr", dreq_addr, 64'h1018);
      check("b2b.ld_strobe", 64'(dreq_strobe), 64'h00);
      check("b2b.sd_out_valid", 64'(out_valid), 64'd1);
      check("b2b.sd_out_pc", out_pc, 64'h200);
      check("b2b.sd_out_regwrite", 64'(out_regwrite), 64'd0);
      @(posedge clk);
      @(negedge clk);
      dresp_data_ok = 1'b0;
      #1;
      check("b2b.ld_out_valid", 64'(out_valid), 64'd1);
      check("b2b.ld_out_result", out_result, 64'h0123_4567_89AB_CDEF);
      check("b2b.ld_out_regwrite", 64'(out_regwrite), 64'd1);
      check("b2b.idle_dreq_valid", 64'(dreq_valid), 64'd0);
      check("b2b.stall_cycles", 64'(stall_cycles), 64'(expStall));

      // Reset while a request is outstanding, then a stray data_ok.
      @(negedge clk);
      driveOp(mkOp(64'h300, 64'h2000, 64'h0, 5'd3, 1, 1, 0, 2'd2, 0));
      @(posedge clk);
      @(negedge clk);
      driveBubble();
      #1;
      check("rstreq.dreq_valid", 64'(dreq_valid), 64'd1);
      check("rstreq.stallM", 64'(stallM), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstreq.after_dreq_valid", 64'(dreq_valid), 64'd0);
      check("rstreq.after_stallM", 64'(stallM), 64'd0);
      check("rstreq.after_out_valid", 64'(out_valid), 64'd0);
      check("rstreq.after_out_pc", out_pc, 64'd0);
      check("rstreq.after_out_result", out_result, 64'd0);
      check("rstreq.after_dreq_addr", dreq_addr, 64'd0);
      check("rstreq.after_stall_cycles", 64'(stall_cycles), 64'd0);
      dresp_data_ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dresp_data_ok = 1'b0;
      #1;
      check("rstreq.stray_out_valid", 64'(out_valid), 64'd0);
      check("rstreq.stray_dreq_valid", 64'(dreq_valid), 64'd0);
      check("rstreq.stray_stallM", 64'(stallM), 64'd0);

      // Randomized traffic against the transaction-level model.
      stageOp = mkOp(64'h0, 64'h0, 64'h0, 5'd0, 0, 0, 0, 2'd0, 0);
      stageOp.valid = 1'b0;
      expOut = modelOut(stageOp, 64'h0);
      stageWait = 0;
      stallCnt = 0;
      nextOp = stageOp;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         busy = stageOp.valid && (stageOp.mr || stageOp.mw) && !isMisaligned(stageOp);
         ok = busy ? (stageWait == 0) : 1'($urandom);
         rdata = {$urandom, $urandom};
         stall = busy && !ok;
         dresp_data_ok = ok;
         dresp_data = rdata;
         if (!stall) nextOp = randOp();
         driveOp(nextOp);
         #1;
         check("rnd.stallM", 64'(stallM), 64'(stall));
         check("rnd.dreq_valid", 64'(dreq_valid), 64'(busy));
         if (busy) begin
            check("rnd.dreq_addr", dreq_addr, stageOp.alu);
            check("rnd.dreq_size", 64'(dreq_size), 64'(stageOp.msize));
            check("rnd.dreq_strobe", 64'(dreq_strobe), 64'(modelStrobe(stageOp)));
            if (stageOp.mw) check("rnd.dreq_data", dreq_data, modelData(stageOp));
         end
         check("rnd.stall_cycles", 64'(stall_cycles), 64'(stallCnt));
         check("rnd.out_valid", 64'(out_valid), 64'(expOut.valid));
         if (expOut.valid) begin
            check("rnd.out_pc", out_pc, expOut.pc);
            check("rnd.out_dst", 64'(out_dst), 64'(expOut.dst));
            check("rnd.out_regwrite", 64'(out_regwrite), 64'(expOut.rw));
            check("rnd.out_misalign", 64'(out_misalign), 64'(expOut.mis));
            if (!expOut.skipResult) check("rnd.out_result", out_result, expOut.result);
         end
         if (stall) begin
            expOut.valid = 1'b0;
            stageWait--;
            stallCnt++;
         end else begin
            expOut = modelOut(stageOp, rdata);
            stageOp = nextOp;
            stageWait = $urandom_range(0, 3);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
